pmu_pg_seq: RTL and testbench

Programmable power-gating sequencer for the core power domain, clocked by the PMU clock.
- Takes a level power-down request from the PMU mode FSM and drives reset, isolation, core sleep handshake and power-switch enable in a fixed order, with programmable inter-step delays.
- Monitors the power-switch acknowledge with a timeout and reports completion and error status back to the PMU register block.

---
 rtl/pmu_pg_pkg.sv | 29 ++
 rtl/pmu_pg_timer.sv | 33 +++
 rtl/pmu_pg_seq.sv | 148 ++++++++++++++
 tb/tb_pmu_pg_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pg_pkg.sv
// Shared state encoding and width defaults for the core power-gating sequencer.
// SAVE/RESTORE codes stay reserved even when PMU_PG_RETENTION_EN is undefined.
package pmu_pg_pkg;

  localparam int DLY_W_DEF = 8;
  localparam int TO_W_DEF  = 12;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_RST_ON  = 4'd1;
  localparam logic [3:0] ST_ISO_ON  = 4'd2;
  localparam logic [3:0] ST_SLP_REQ = 4'd3;
  localparam logic [3:0] ST_SAVE    = 4'd4;
  localparam logic [3:0] ST_PSW_OFF = 4'd5;
  localparam logic [3:0] ST_OFF     = 4'd6;
  localparam logic [3:0] ST_PSW_ON  = 4'd7;
  localparam logic [3:0] ST_RESTORE = 4'd8;
  localparam logic [3:0] ST_ISO_OFF = 4'd9;
  localparam logic [3:0] ST_RST_OFF = 4'd10;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Steps that last step_dly+1 cycles
  function automatic logic is_timed_step(input logic [3:0] s);
    return s inside {ST_RST_ON, ST_ISO_ON, ST_SAVE, ST_RESTORE, ST_ISO_OFF, ST_RST_OFF};
  endfunction

endpackage

// File: rtl/pmu_pg_timer.sv
// Loadable down-counter: expire pulses for one cycle when an armed count reaches zero, then disarms.
// Shared by step delays and power-switch timeouts; zero_dis loads the counter disarmed.
module pmu_pg_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         zero_dis,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic         armed;

  assign expire = en && armed && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= ~zero_dis;
    end else if (en && armed) begin
      if (cnt == '0) armed <= 1'b0;
      else           cnt   <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/pmu_pg_seq.sv
// Core power-gating sequencer: reset -> isolation -> sleep handshake -> switch off, and back on wakeup.
// Outputs are registered from the next state; PMU_PG_RETENTION_EN adds the SAVE/RESTORE steps and ports.
module pmu_pg_seq
  import pmu_pg_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF,
  parameter int TO_W  = TO_W_DEF,
  parameter int CNT_W = max_w(DLY_W, TO_W)
) (
  input  logic             pmu_clk,
  input  logic             pad_cpu_rst_b,
  input  logic             pg_req,
  input  logic             wakeup,
  input  logic [DLY_W-1:0] step_dly,
  input  logic [TO_W-1:0]  psw_timeout,
  input  logic             err_clr,
  input  logic             corec_pmu_sleep_out,
  input  logic             psw_ack,
  output logic             pg_rst_b,
  output logic             pg_iso,
  output logic             pmu_corec_sleep_in,
  output logic             psw_en,
  output logic             pg_busy,
  output logic             pg_done,
  output logic             pg_err
`ifdef PMU_PG_RETENTION_EN
  ,
  output logic             ret_save,
  output logic             ret_restore
`endif
);

`ifdef PMU_PG_RETENTION_EN
  localparam logic [3:0] SLP_NEXT = ST_SAVE;
  localparam logic [3:0] PSW_NEXT = ST_RESTORE;
`else
  localparam logic [3:0] SLP_NEXT = ST_PSW_OFF;
  localparam logic [3:0] PSW_NEXT = ST_ISO_OFF;
`endif

  logic [3:0]       state;
  logic [3:0]       state_nx;
  logic             err_set;
  logic             tmr_load;
  logic             tmr_dis;
  logic             tmr_en;
  logic             tmr_exp;
  logic [CNT_W-1:0] tmr_val;

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    case (state)
      ST_IDLE:    if (pg_req && !pg_err) state_nx = ST_RST_ON;
      ST_RST_ON:  if (tmr_exp) state_nx = ST_ISO_ON;
      ST_ISO_ON:  if (tmr_exp) state_nx = ST_SLP_REQ;
      ST_SLP_REQ: begin
        if (corec_pmu_sleep_out) state_nx = SLP_NEXT;
        else if (!pg_req)        state_nx = ST_ISO_OFF;
      end
      ST_PSW_OFF: begin
        if (!psw_ack) begin
          state_nx = ST_OFF;
        end else if (tmr_exp) begin
          state_nx = ST_PSW_ON;
          err_set  = 1'b1;
        end
      end
      ST_OFF:     if (wakeup) state_nx = ST_PSW_ON;
      // Timeout while powering up only flags the error; the domain must still come up.
      ST_PSW_ON: begin
        if (psw_ack)      state_nx = PSW_NEXT;
        else if (tmr_exp) err_set  = 1'b1;
      end
`ifdef PMU_PG_RETENTION_EN
      ST_SAVE:    if (tmr_exp) state_nx = ST_PSW_OFF;
      ST_RESTORE: if (tmr_exp) state_nx = ST_ISO_OFF;
`endif
      ST_ISO_OFF: if (tmr_exp) state_nx = ST_RST_OFF;
      ST_RST_OFF: if (tmr_exp) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // The timer is reloaded on every state change, so each delay value is captured at step entry.
  always_comb begin
    tmr_load = (state_nx != state);
    tmr_val  = '0;
    tmr_dis  = 1'b1;
    if (is_timed_step(state_nx)) begin
      tmr_val = CNT_W'(step_dly);
      tmr_dis = 1'b0;
    end else if (state_nx == ST_PSW_OFF || state_nx == ST_PSW_ON) begin
      tmr_val = CNT_W'(psw_timeout - TO_W'(1));
      tmr_dis = (psw_timeout == '0);
    end
  end

  assign tmr_en = (state != ST_IDLE);

  pmu_pg_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (pmu_clk),
    .rst_b    (pad_cpu_rst_b),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_dis (tmr_dis),
    .en       (tmr_en),
    .expire   (tmr_exp)
  );

  always_ff @(posedge pmu_clk) begin
    if (!pad_cpu_rst_b) begin
      state              <= ST_IDLE;
      pg_rst_b           <= 1'b1;
      pg_iso             <= 1'b0;
      pmu_corec_sleep_in <= 1'b0;
      psw_en             <= 1'b1;
      pg_busy            <= 1'b0;
      pg_done            <= 1'b0;
      pg_err             <= 1'b0;
    end else begin
      state              <= state_nx;
      pg_rst_b           <= (state_nx == ST_IDLE);
      pg_iso             <= state_nx inside {ST_ISO_ON, ST_SLP_REQ, ST_SAVE, ST_PSW_OFF,
                                             ST_OFF, ST_PSW_ON, ST_RESTORE, ST_ISO_OFF};
      pmu_corec_sleep_in <= state_nx inside {ST_SLP_REQ, ST_SAVE, ST_PSW_OFF, ST_OFF};
      psw_en             <= !(state_nx inside {ST_PSW_OFF, ST_OFF});
      pg_busy            <= (state_nx != ST_IDLE);
      pg_done            <= (state == ST_RST_OFF) && (state_nx == ST_IDLE);
      pg_err             <= err_set | (pg_err & ~err_clr);
    end
  end

`ifdef PMU_PG_RETENTION_EN
  always_ff @(posedge pmu_clk) begin
    if (!pad_cpu_rst_b) begin
      ret_save    <= 1'b0;
      ret_restore <= 1'b0;
    end else begin
      ret_save    <= (state_nx == ST_SAVE);
      ret_restore <= (state_nx == ST_RESTORE);
    end
  end
`endif

endmodule

// File: tb/tb_pmu_pg_seq.sv
// Bench for pmu_pg_seq: phase-level model predicts each output change edge; a monitor checks every change.
module tb_pmu_pg_seq;

  localparam int INF = 1 << 30;
  // {pg_rst_b, pg_iso, sleep_in, psw_en, pg_busy, pg_done, pg_err}
  localparam logic [6:0] RST_VEC = 7'b1001000;

  typedef struct {
    int         edge_n;
    logic [6:0] vec;
  } exp_t;

  logic        pmu_clk = 1'b0;
  logic        pad_cpu_rst_b;
  logic        pg_req;
  logic        wakeup;
  logic [7:0]  step_dly;
  logic [11:0] psw_timeout;
  logic        err_clr;
  logic        corec_pmu_sleep_out;
  logic        psw_ack;
  logic        pg_rst_b;
  logic        pg_iso;
  logic        pmu_corec_sleep_in;
  logic        psw_en;
  logic        pg_busy;
  logic        pg_done;
  logic        pg_err;

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         mon_on = 1'b0;
  bit         m_err = 1'b0;
  logic [6:0] m_last = RST_VEC;
  exp_t       exp_q[$];

  always #5 pmu_clk = ~pmu_clk;
  always @(posedge pmu_clk) cyc <= cyc + 1;

  pmu_pg_seq dut (
    .pmu_clk             (pmu_clk),
    .pad_cpu_rst_b       (pad_cpu_rst_b),
    .pg_req              (pg_req),
    .wakeup              (wakeup),
    .step_dly            (step_dly),
    .psw_timeout         (psw_timeout),
    .err_clr             (err_clr),
    .corec_pmu_sleep_out (corec_pmu_sleep_out),
    .psw_ack             (psw_ack),
    .pg_rst_b            (pg_rst_b),
    .pg_iso              (pg_iso),
    .pmu_corec_sleep_in  (pmu_corec_sleep_in),
    .psw_en              (psw_en),
    .pg_busy             (pg_busy),
    .pg_done             (pg_done),
    .pg_err              (pg_err)
  );

  function automatic logic [6:0] mk(bit rb, bit iso, bit slp, bit pe, bit busy, bit done, bit err);
    return {rb, iso, slp, pe, busy, done, err};
  endfunction

  task automatic step();
    @(posedge pmu_clk);
    #1;
  endtask

  task automatic push_exp(input int n, input logic [6:0] v);
    exp_t ex;
    if (v != m_last) begin
      ex.edge_n = n;
      ex.vec    = v;
      exp_q.push_back(ex);
      m_last = v;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    pg_req = 1'b0; wakeup = 1'b0; err_clr = 1'b0;
    corec_pmu_sleep_out = 1'b0; psw_ack = 1'b1; pad_cpu_rst_b = 1'b1;
  endtask

  // With pg_err set, a held request must be ignored until err_clr.
  task automatic clear_err(input int k);
    repeat (k) begin
      pg_req = 1'b1;
      step();
    end
    err_clr = 1'b1;
    push_exp(cyc + 1, RST_VEC);
    step();
    err_clr = 1'b0;
    pg_req  = 1'b0;
    m_err   = 1'b0;
  endtask

  // mode: 0 full cycle, 1 abort in SLP_REQ, 2 power-off timeout, 3 reset in OFF, 4 hold in PSW_OFF then reset
  task automatic run_seq(input int d, input int t, input int s, input int mode, input int p,
                         input int wk, input int q, input bit early, input bit coinc,
                         input bit clr_at_err, input int hold);
    int e0, a1, a, b, c, dd, e, f, g, rst_edge, clr_edge, req_off, end_e, sl_end, n;
    bit ack_low;
    if (m_err) clear_err(int'($urandom_range(1, 4)));
    e0 = cyc + 1;
    a1 = e0 + d + 1;
    a  = a1 + d + 1;
    b = INF; c = INF; dd = INF; e = INF; f = INF; g = INF; rst_edge = INF; clr_edge = INF;
    push_exp(e0, mk(0, 0, 0, 1, 1, 0, m_err));
    push_exp(a1, mk(0, 1, 0, 1, 1, 0, m_err));
    push_exp(a,  mk(0, 1, 1, 1, 1, 0, m_err));
    if (mode == 1) begin
      e = a + s;
    end else begin
      b = a + s;
      push_exp(b, mk(0, 1, 1, 0, 1, 0, m_err));
      case (mode)
        0: begin
          c  = b + p;
          dd = c + wk;
          e  = dd + q;
          push_exp(dd, mk(0, 1, 0, 1, 1, 0, m_err));
          if (t != 0 && q > t) begin
            m_err = 1'b1;
            if (clr_at_err) clr_edge = dd + t;
            push_exp(dd + t, mk(0, 1, 0, 1, 1, 0, 1));
          end
        end
        2: begin
          dd = b + t;
          e  = dd + 1;
          m_err = 1'b1;
          if (clr_at_err) clr_edge = dd;
          push_exp(dd, mk(0, 1, 0, 1, 1, 0, 1));
        end
        3: begin
          c = b + p;
          rst_edge = c + 1;
        end
        default: rst_edge = b + hold;
      endcase
    end
    if (rst_edge != INF) begin
      m_err = 1'b0;
      push_exp(rst_edge, RST_VEC);
      end_e = rst_edge + 1;
    end else begin
      f = e + d + 1;
      g = f + d + 1;
      push_exp(e, mk(0, 1, 0, 1, 1, 0, m_err));
      push_exp(f, mk(0, 0, 0, 1, 1, 0, m_err));
      push_exp(g, mk(1, 0, 0, 1, 0, 1, m_err));
      push_exp(g + 1, mk(1, 0, 0, 1, 0, 0, m_err));
      end_e = g + 1;
    end
    req_off = (mode == 1) ? a + s : a + s + (coinc ? 0 : 1);
    sl_end  = (e == INF) ? rst_edge : e;

    while (cyc < end_e) begin
      n = cyc + 1;
      ack_low = (mode == 0 || mode == 3) && n >= b + p && n < dd + q;
      pg_req  = (n >= e0 && n < req_off);
      corec_pmu_sleep_out = (mode != 1) && n >= a + s && n < sl_end;
      psw_ack = !ack_low;
      wakeup  = early ? (n >= e0 && n < sl_end) : (mode == 0 && n >= c + wk && n < e);
      err_clr = (n == clr_edge);
      pad_cpu_rst_b = (n != rst_edge);
      step_dly = (n == e0 || n == a1 || n == e || n == f) ? 8'(d) : 8'($urandom_range(0, 255));
      psw_timeout = (n == b || n == dd) ? 12'(t) : 12'($urandom_range(0, 4095));
      step();
    end
    idle_inputs();
  endtask

  // Monitor: every observed output change must match the next predicted change and its edge.
  initial begin
    logic [6:0] cur;
    logic [6:0] prev;
    exp_t       ex;
    prev = RST_VEC;
    forever begin
      @(negedge pmu_clk);
      if (mon_on) begin
        cur = {pg_rst_b, pg_iso, pmu_corec_sleep_in, psw_en, pg_busy, pg_done, pg_err};
        if (cur !== prev) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change: edge %0d got %b, no change expected", cyc, cur);
          end else begin
            ex = exp_q.pop_front();
            if (ex.edge_n != cyc || ex.vec !== cur) begin
              n_fail++;
              $display("FAIL out_change: edge %0d got %b, expected edge %0d value %b",
                       cyc, cur, ex.edge_n, ex.vec);
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    pad_cpu_rst_b = 1'b0;
    step_dly = 8'd0;
    psw_timeout = 12'd0;
    repeat (3) step();
    @(negedge pmu_clk);
    chk("rst_pg_rst_b", pg_rst_b, 1'b1);
    chk("rst_pg_iso", pg_iso, 1'b0);
    chk("rst_sleep_in", pmu_corec_sleep_in, 1'b0);
    chk("rst_psw_en", psw_en, 1'b1);
    chk("rst_pg_busy", pg_busy, 1'b0);
    chk("rst_pg_done", pg_done, 1'b0);
    chk("rst_pg_err", pg_err, 1'b0);
    step();
    pad_cpu_rst_b = 1'b1;
    mon_on = 1'b1;
    step();

    //      d  t    s  mode p  wk  q  early coinc clr hold
    run_seq(2, 100, 5, 0,   3, 10, 2, 0,    0,    0,  0);
    step();
    run_seq(1, 20,  4, 1,   0, 0,  0, 0,    0,    0,  0);
    step();
    run_seq(1, 8,   2, 2,   0, 0,  0, 0,    0,    1,  0);
    step();
    run_seq(1, 50,  3, 0,   2, 1,  3, 1,    0,    0,  0);
    step();
    run_seq(1, 50,  2, 3,   2, 0,  0, 0,    0,    0,  0);
    step();
    run_seq(0, 0,   1, 4,   0, 0,  0, 0,    0,    0,  30);
    step();
    run_seq(0, 5,   2, 0,   5, 2,  5, 0,    1,    0,  0);
    step();

    for (int i = 0; i < 25; i++) begin
      int  md, d, t, s, p, wk, q;
      bit  early;
      md = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 5));
      if (md == 2)                          t = int'($urandom_range(1, 12));
      else if ($urandom_range(0, 3) == 0)   t = 0;
      else                                  t = int'($urandom_range(1, 20));
      s  = int'($urandom_range(1, 6));
      p  = (t == 0) ? int'($urandom_range(1, 10)) : int'($urandom_range(1, t));
      q  = int'($urandom_range(1, 25));
      early = (md == 0) && ($urandom_range(0, 3) == 0);
      wk = early ? 1 : int'($urandom_range(1, 8));
      run_seq(d, t, s, md, p, wk, q, early, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      repeat (int'($urandom_range(0, 3))) step();
    end

    repeat (4) step();
    while (exp_q.size() > 0) begin
      exp_t ex;
      ex = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_change: expected value %b at edge %0d, never observed", ex.vec, ex.edge_n);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
